// File: rtl/fpm_arbiter.sv
// fpm_arbiter: two-requester round-robin front end for one shared, fully
// pipelined floating-point multiplier. Operands are registered into the
// multiplier; a {valid, id} tag pipeline runs in step with the multiplier.
// Each returning product is steered back to the requester that issued it.
// A drain FSM lets the host stop issuing and wait for the pipe to empty.
module fpm_arbiter #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             drain,
  output logic             mul_issue,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  output logic             res0_valid,
  output logic             res1_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       inflight,
  output logic             idle
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    DRAINING     = 2'd1,
    IDLE_DRAINED = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic ptr_reg;

  logic grant0, grant1, hs, res_done;

  // Tag pipeline: bit 0 is loaded with the issue, bit LATENCY is the tail
  // that lines up with the product appearing on mul_result.
  logic [LATENCY:0] tag_valid_reg;
  logic [LATENCY:0] tag_id_reg;

  // Drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Drain FSM next state; leaving drain always wins over completing it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (drain) state_next = DRAINING;
      end
      DRAINING: begin
        if (!drain) begin
          state_next = RUN;
        end else if (inflight == 5'd0 && !mul_issue) begin
          state_next = IDLE_DRAINED;
        end
      end
      IDLE_DRAINED: begin
        if (!drain) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign idle = (state_reg == IDLE_DRAINED);

  // Round-robin grant; drain blocks requests in the very cycle it rises
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == RUN && !drain) begin
      if (req0_valid && (!req1_valid || !ptr_reg)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs         = grant0 | grant1;
  assign res_done   = res0_valid | res1_valid;

  // Priority pointer moves to the requester that was not just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (grant0) begin
      ptr_reg <= 1'b1;
    end else if (grant1) begin
      ptr_reg <= 1'b0;
    end
  end

  // Operand register into the multiplier; operands hold when nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_issue <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_issue <= hs;
      if (grant0) begin
        mul_a <= req0_a;
        mul_b <= req0_b;
      end else if (grant1) begin
        mul_a <= req1_a;
        mul_b <= req1_b;
      end
    end
  end

  // Tag shift register; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[LATENCY-1:0], hs};
      tag_id_reg    <= {tag_id_reg[LATENCY-1:0], grant1};
    end
  end

  // Result capture and routing back to the issuing requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res_data   <= '0;
    end else begin
      res0_valid <= tag_valid_reg[LATENCY] & ~tag_id_reg[LATENCY];
      res1_valid <= tag_valid_reg[LATENCY] &  tag_id_reg[LATENCY];
      if (tag_valid_reg[LATENCY]) begin
        res_data <= mul_result;
      end
    end
  end

  // Operations in flight, counted until their result pulse has been
  // presented; bounded by the LATENCY+1 tag stages plus the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 5'd0;
    end else if (hs && !res_done) begin
      inflight <= inflight + 5'd1;
    end else if (!hs && res_done) begin
      inflight <= inflight - 5'd1;
    end
  end

endmodule

// File: tb/tb_fpm_arbiter.sv
// Bench for fpm_arbiter: handshakes push expected {id, product, cycle} into a
// scoreboard queue; a monitor pops and checks every result pulse.
module tb_fpm_arbiter;

  localparam int LATENCY = 4;
  localparam int WIDTH   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             drain;
  logic             mul_issue;
  logic [WIDTH-1:0] mul_a, mul_b, mul_result;
  logic             res0_valid, res1_valid;
  logic [WIDTH-1:0] res_data;
  logic [4:0]       inflight;
  logic             idle;

  fpm_arbiter #(.LATENCY(LATENCY), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .drain(drain),
    .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic [31:0] cyc = 0;
  logic [31:0] req0_exp, req1_exp;
  logic [31:0] mul_pipe [0:LATENCY-1];

  // Hand-computed IEEE single operand pairs for contention
  logic [31:0] c0a [0:2] = '{32'h40400000, 32'h40000000, 32'hBFC00000};
  logic [31:0] c0b [0:2] = '{32'h40000000, 32'h3F000000, 32'h40800000};
  logic [31:0] c0e [0:2] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000};
  logic [31:0] c1a [0:2] = '{32'h3F000000, 32'h40800000, 32'hC0000000};
  logic [31:0] c1b [0:2] = '{32'h3F000000, 32'h40800000, 32'h40400000};
  logic [31:0] c1e [0:2] = '{32'h3E800000, 32'h41800000, 32'hC0C00000};

  // Non-commutative stand-in product for bulk integer operands
  function automatic logic [31:0] scramble(input logic [31:0] a, input logic [31:0] b);
    return (a * 32'd3) ^ b;
  endfunction

  // Behavioural multiplier: exact products for the FP vectors used here
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_40000000: return 32'h40C00000;
      64'h40000000_3F000000: return 32'h3F800000;
      64'hBFC00000_40800000: return 32'hC0C00000;
      64'h3F000000_3F000000: return 32'h3E800000;
      64'h40800000_40800000: return 32'h41800000;
      64'hC0000000_40400000: return 32'hC0C00000;
      default:               return scramble(a, b);
    endcase
  endfunction

  // Multiplier pipeline model; emits garbage when nothing was issued
  always @(posedge clk) begin
    mul_pipe[0] <= mul_issue ? fpmul(mul_a, mul_b) : {16'hDEAD, cyc[15:0]};
    for (int i = 1; i < LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[LATENCY-1];

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Scoreboard producer: record each accepted operation
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, req0_exp, cyc});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, req1_exp, cyc});
    end
  end

  // Scoreboard consumer: every result pulse must match the oldest entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (res0_valid || res1_valid)) begin
      pulse_cnt++;
      checks++;
      if (res0_valid && res1_valid) begin
        errors++;
        $display("FAIL res_both actual res0=1 res1=1 required one-hot");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected actual id=%0d data=%h required no pulse", res1_valid, res_data);
      end else begin
        e = exp_q.pop_front();
        if (res1_valid !== e.id || res_data !== e.data || (cyc - e.cyc) != LATENCY + 2) begin
          errors++;
          $display("FAIL result actual id=%0d data=%h lat=%0d required id=%0d data=%h lat=%0d",
                   res1_valid, res_data, cyc - e.cyc, e.id, e.data, LATENCY + 2);
        end else begin
          $display("result id=%0d data=%h lat=%0d", e.id, e.data, cyc - e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_a;
    int n0, n1, p;
    bit seen0, done;

    rst = 1'b1; drain = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_exp = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_exp = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_issue", mul_issue, 0);
    chk("rst_res0", res0_valid, 0);
    chk("rst_res1", res1_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;

    // Single issue 3.0 * 2.0
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h40000000; req0_exp = 32'h40C00000;
    #1 chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("single_issue", mul_issue, 1);
    chk("single_mul_a", mul_a, 32'h40400000);
    chk("single_mul_b", mul_b, 32'h40000000);
    chk("single_inflight", inflight, 1);
    @(negedge clk);
    chk("single_issue_drop", mul_issue, 0);
    chk("single_a_hold", mul_a, 32'h40400000);
    repeat (8) @(negedge clk);
    chk("single_inflight_end", inflight, 0);

    // req1 alone, moves pointer to requester 0
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h3F000000; req1_b = 32'h3F000000; req1_exp = 32'h3E800000;
    #1 chk("fair_rdy1", req1_ready, 1);
    chk("fair_rdy0", req0_ready, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Contention: grants alternate starting with requester 0
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = c0a[n0]; req0_b = c0b[n0]; req0_exp = c0e[n0];
      req1_valid = 1'b1; req1_a = c1a[n1]; req1_b = c1b[n1]; req1_exp = c1e[n1];
      #1 chk("cont_rdy0", req0_ready, (i % 2 == 0));
      chk("cont_rdy1", req1_ready, (i % 2 == 1));
      if (i % 2 == 0) n0++; else n1++;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 chk("cont_inflight_peak", inflight, 6);
    repeat (10) @(negedge clk);
    chk("cont_inflight_end", inflight, 0);

    // Drain with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h01000000 + i; req0_b = 32'h00000010 + i;
      req0_exp = scramble(req0_a, req0_b);
      #1 chk("drain_pre_rdy0", req0_ready, 1);
    end
    @(negedge clk);
    drain = 1'b1;
    req0_a = 32'h01000100; req0_b = 32'h00000200; req0_exp = scramble(req0_a, req0_b);
    req1_valid = 1'b1; req1_a = 32'h02000300; req1_b = 32'h00000400;
    req1_exp = scramble(req1_a, req1_b);
    #1 chk("drain_rdy0", req0_ready, 0);
    chk("drain_rdy1", req1_ready, 0);
    seen0 = 1'b0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      #1;
      if (req0_ready || req1_ready) chk("drain_rdy_low", {req0_ready, req1_ready}, 0);
      if (seen0) begin
        chk("drain_idle_rise", idle, 1);
        done = 1'b1;
      end else if (inflight == 5'd0) begin
        chk("drain_idle_low", idle, 0);
        seen0 = 1'b1;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(negedge clk);
    drain = 1'b0;
    #1 chk("undrain_rdy0", req0_ready, 0);
    chk("undrain_rdy1", req1_ready, 0);
    chk("undrain_idle", idle, 1);
    @(negedge clk);
    #1 chk("resume_rdy1", req1_ready, 1);
    chk("resume_rdy0", req0_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Reset with two operations in flight
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h03000000 + i; req0_b = 32'h00000020 + i;
      req0_exp = scramble(req0_a, req0_b);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    p = pulse_cnt;
    #1 chk("midrst_issue", mul_issue, 0);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_mul_a", mul_a, 0);
    chk("midrst_mul_b", mul_b, 0);
    chk("midrst_res_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);
    chk("midrst_no_pulse", pulse_cnt, p);
    chk("midrst_inflight_after", inflight, 0);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h04000000; req0_b = 32'h00000030;
    req0_exp = scramble(req0_a, req0_b);
    req1_valid = 1'b1; req1_a = 32'h05000000; req1_b = 32'h00000040;
    req1_exp = scramble(req1_a, req1_b);
    #1 chk("midrst_ptr_rdy0", req0_ready, 1);
    chk("midrst_ptr_rdy1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Stall-free throughput from requester 0
    prev_a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h20000000 + 32'(i * 7); req0_b = 32'h00001000 + 32'(i);
      req0_exp = scramble(req0_a, req0_b);
      #1 chk("tput_rdy0", req0_ready, 1);
      chk("tput_issue", mul_issue, (i > 0));
      if (i > 0) chk("tput_mul_a", mul_a, prev_a);
      chk("tput_res0", res0_valid, (i >= LATENCY + 2));
      if (i == 10) chk("tput_inflight_max", inflight, LATENCY + 2);
      prev_a = req0_a;
    end
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1 chk("tput_tail_res0", res0_valid, (j < LATENCY + 2));
      chk("tput_tail_issue", mul_issue, (j == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpm_arbiter.md
Name: fpm_arbiter

Overview:
- Shares one pipelined 32-bit floating-point multiplier between two requesters.
- Each requester offers operand pairs through a valid/ready handshake; a round-robin arbiter grants one request per cycle.
- The block registers the operands into the multiplier and carries a tag pipeline in step with the multiplier datapath. The returning product is routed back to the requester that issued it.
- A drain state machine lets the host stop new issues and wait until no operations are in flight.

Parameters:
- LATENCY, 4: clocks from mul_issue high to the matching product being valid on mul_result; legal range 1-15.
- WIDTH, 32: operand and result width (IEEE single).

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 grant; transfer on valid & ready
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- drain  in  1  level; stop accepting new requests
- mul_issue  out  1  operands on mul_a/mul_b valid this cycle
- mul_a, mul_b  out  WIDTH  registered operands to the multiplier
- mul_result  in  WIDTH  multiplier product, LATENCY clocks after mul_issue
- res0_valid, res1_valid  out  1  one-cycle pulse: res_data belongs to requester 0 / 1
- res_data  out  WIDTH  registered product
- inflight  out  5  count of issued operations not yet returned
- idle  out  1  state==IDLE_DRAINED

Behaviour:
- Reset (async):
  - mul_issue, res0_valid, res1_valid, inflight and idle are 0; mul_a, mul_b and res_data are 0.
  - The priority pointer points to requester 0. The FSM goes to RUN. All tag-pipeline valid bits are cleared.
- FSM states: RUN, DRAINING, IDLE_DRAINED.
  - RUN -> DRAINING when drain=1.
  - DRAINING -> IDLE_DRAINED when inflight==0 and no issue is pending.
  - DRAINING or IDLE_DRAINED -> RUN when drain=0, taking effect on the next cycle.
  - RUN with drain=1 and inflight==0 goes through DRAINING for one cycle, then to IDLE_DRAINED.
- Grant:
  - Only in RUN with drain=0. reqN_ready is combinational from the valid inputs, the pointer, state and drain.
  - If only one requester is valid, that requester gets ready.
  - If both are valid, the pointer's requester wins.
  - When requester N is granted, the pointer moves to the other requester on the next edge. With no grant the pointer holds.
  - readies are never asserted outside RUN. At most one ready is high per cycle.
- Issue:
  - A handshake at edge T registers the operands into mul_a/mul_b and sets mul_issue=1 for cycle T+1.
  - With no handshake, mul_issue=0 and mul_a/mul_b hold their values.
  - Back-to-back issue every cycle is allowed; the multiplier is fully pipelined.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}, entered alongside mul_issue.
  - When the tail valid is set at cycle T+1+LATENCY, mul_result is captured into res_data.
  - The matching resN_valid pulses at T+2+LATENCY. Total handshake-to-result latency is LATENCY+2 clocks.
  - res_data holds its value until the next capture.
- inflight:
  - Increments on a handshake and decrements on a result capture. A simultaneous increment and decrement leaves it unchanged.
  - The maximum is LATENCY+2, and it never wraps.
- No result backpressure: requesters must accept the resN_valid pulse.
- Ordering: results return in issue order, both globally and per requester.
- Reset mid-operation: in-flight tags are discarded. No resN_valid fires for operations issued before reset, even though mul_result may still change.
- Simultaneous events:
  - drain rising in the same cycle as a valid request blocks that request, because ready is low that cycle.
  - Results already in flight still complete during DRAINING.

Test Plan:
- Single issue, LATENCY=4: req0 sends a=0x40400000 (3.0), b=0x40000000 (2.0); a behavioural multiplier model returns mul_result=0x40C00000 (6.0) on cycle T+5 -> res0_valid pulses on cycle T+6 with res_data=0x40C00000, and res1_valid stays 0.
- Contention: both requesters hold valid for 6 cycles -> grants alternate 0,1,0,1,0,1; six results return in the same order with the correct ids; inflight peaks at 6.
- Fairness after idle: req1 alone is granted, then both are valid -> req0 wins the next cycle, because the pointer advanced to 0.
- Drain: issue 3 operations, then assert drain -> readies drop that cycle, the 3 results still arrive, and idle rises the cycle after inflight reaches 0. Deasserting drain -> grants resume on the next cycle.
- Reset mid-flight: issue 2 operations, then pulse rst 2 cycles later -> outputs go to 0 immediately, no resN_valid pulse occurs for the next LATENCY+2 cycles, and inflight=0.
- Stall-free throughput: req0 valid continuously for 20 cycles -> 20 consecutive mul_issue cycles and 20 results in order, with no gaps.
